// File: rtl/instr_fetch_unit.sv
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Single-issue fetch stage for a synchronous instruction memory,
//                with stall holding and branch redirect/flush.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        pc_out,
    output logic [31:0]        instruction_out,
    output logic               valid_out
);

    logic [31:0] r_pc_reg;
    logic [31:0] r_req_pc;
    logic        r_req_valid;
    logic [31:0] r_hold_instr;
    logic        r_hold_valid;
    logic [31:0] r_pc_out;
    logic [31:0] r_instr_out;
    logic        r_valid_out;

    logic [31:0] w_branch_target;
    logic [31:0] w_instr_src;
    logic        w_unused_ok;

    assign w_branch_target = {branch_addr[31:2], 2'b00};
    assign w_unused_ok     = &{1'b0, branch_addr[1:0]};

    // Memory returns data one cycle after the address; a stalled word is
    // parked in the hold register because the read port keeps re-reading.
    assign w_instr_src = r_hold_valid ? r_hold_instr : imem_rdata;

    assign imem_addr       = r_pc_reg[IMEM_AW+1:2];
    assign pc_out          = r_pc_out;
    assign instruction_out = r_instr_out;
    assign valid_out       = r_valid_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_reg     <= RESET_PC;
            r_req_pc     <= 32'h0;
            r_req_valid  <= 1'b0;
            r_hold_instr <= 32'h0;
            r_hold_valid <= 1'b0;
            r_pc_out     <= 32'h0;
            r_instr_out  <= 32'h0;
            r_valid_out  <= 1'b0;
        end else if (branch_taken) begin
            r_pc_reg     <= w_branch_target;
            r_req_valid  <= 1'b0;
            r_hold_valid <= 1'b0;
            r_valid_out  <= 1'b0;
        end else if (stall) begin
            // Capture only on the first stall cycle so later re-reads are ignored
            if (r_req_valid && !r_hold_valid) begin
                r_hold_instr <= imem_rdata;
                r_hold_valid <= 1'b1;
            end
        end else begin
            r_pc_reg     <= r_pc_reg + 32'd4;
            r_req_pc     <= r_pc_reg;
            r_req_valid  <= 1'b1;
            r_pc_out     <= r_req_pc;
            r_instr_out  <= w_instr_src;
            r_valid_out  <= r_req_valid;
            r_hold_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam int          c_AW   = 8;
    localparam logic [31:0] c_BASE = 32'hE280_0000;

    logic            clk;
    logic            rst;
    logic            stall;
    logic            branch_taken;
    logic [31:0]     branch_addr;
    logic [c_AW-1:0] imem_addr;
    logic [31:0]     imem_rdata;
    logic [31:0]     pc_out;
    logic [31:0]     instruction_out;
    logic            valid_out;

    logic [31:0] mem [256];
    int n_tests;
    int n_fail;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IMEM_AW  (c_AW)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory, word[i] = E2800000 + i
    always @(posedge clk) imem_rdata <= mem[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", tag, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check_eq({tag, ".valid"}, {31'h0, valid_out}, 32'h1);
        check_eq({tag, ".pc"}, pc_out, pc);
        check_eq({tag, ".instr"}, instruction_out, ins);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        for (int i = 0; i < 256; i++) mem[i] = c_BASE + 32'(i);
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
        step(); step();
        check_eq("rst.pc", pc_out, 32'h0);
        check_eq("rst.instr", instruction_out, 32'h0);
        check_eq("rst.valid", {31'h0, valid_out}, 32'h0);
        check_eq("rst.addr", {24'h0, imem_addr}, 32'h0);

        // Streaming from reset
        rst = 1'b0;
        step(); check_eq("e1.valid", {31'h0, valid_out}, 32'h0);
        step(); check_out("s0", 32'h0, c_BASE + 32'h0);
        step(); check_out("s4", 32'h4, c_BASE + 32'h1);
        step(); check_out("s8", 32'h8, c_BASE + 32'h2);

        // Three-cycle stall while pc=8 is presented
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); check_out("stall", 32'h8, c_BASE + 32'h2);
        end
        stall = 1'b0;
        step(); check_out("relC", 32'hC, c_BASE + 32'h3);
        step(); check_out("rel10", 32'h10, c_BASE + 32'h4);

        // Move pc_reg to 0x14, then redirect to 0x43 from there
        branch_taken = 1'b1; branch_addr = 32'h0000_0014;
        step(); check_eq("br14.valid", {31'h0, valid_out}, 32'h0);
        check_eq("br14.addr", {24'h0, imem_addr}, 32'h5);
        branch_addr = 32'h0000_0043;
        step(); check_eq("br43.valid", {31'h0, valid_out}, 32'h0);
        check_eq("br43.addr", {24'h0, imem_addr}, 32'h10);
        branch_taken = 1'b0;
        step(); check_eq("br43.bubble", {31'h0, valid_out}, 32'h0);
        step(); check_out("t40", 32'h40, c_BASE + 32'h10);
        step(); check_out("t44", 32'h44, c_BASE + 32'h11);

        // Branch and stall together: branch wins
        stall = 1'b1; branch_taken = 1'b1; branch_addr = 32'h0000_0080;
        step(); check_eq("bs.valid", {31'h0, valid_out}, 32'h0);
        check_eq("bs.addr", {24'h0, imem_addr}, 32'h20);
        branch_taken = 1'b0;
        step(); check_eq("bs.hold_addr", {24'h0, imem_addr}, 32'h20);
        check_eq("bs.hold_valid", {31'h0, valid_out}, 32'h0);
        stall = 1'b0;
        step(); check_eq("bs.bubble", {31'h0, valid_out}, 32'h0);
        step(); check_out("t80", 32'h80, c_BASE + 32'h20);

        // Stall to fill the hold register, then reset mid-stall
        stall = 1'b1;
        step(); check_out("hold80", 32'h80, c_BASE + 32'h20);
        rst = 1'b1;
        step();
        check_eq("mr.pc", pc_out, 32'h0);
        check_eq("mr.instr", instruction_out, 32'h0);
        check_eq("mr.valid", {31'h0, valid_out}, 32'h0);
        check_eq("mr.addr", {24'h0, imem_addr}, 32'h0);
        rst = 1'b0; stall = 1'b0;
        step(); check_eq("mr.e1", {31'h0, valid_out}, 32'h0);
        step(); check_out("mr0", 32'h0, c_BASE + 32'h0);
        step(); check_out("mr4", 32'h4, c_BASE + 32'h1);

        // PC wrap-around
        branch_taken = 1'b1; branch_addr = 32'hFFFF_FFF8;
        step(); check_eq("wr.valid", {31'h0, valid_out}, 32'h0);
        branch_taken = 1'b0;
        step();
        step(); check_out("wF8", 32'hFFFF_FFF8, c_BASE + 32'hFE);
        step(); check_out("wFC", 32'hFFFF_FFFC, c_BASE + 32'hFF);
        step(); check_out("w00", 32'h0, c_BASE + 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
